// File: rtl/ltc2308_serial_ctrl_if.sv
// Sample stream between the LTC2308 controller and its consumer.
// A sample is transferred in a cycle where sample_valid and sample_ready are both high.
interface ltc2308_serial_ctrl_if;
    logic [11:0] sample_data;
    logic [2:0]  sample_channel;
    logic        sample_uni;
    logic        sample_valid;
    logic        sample_ready;

    modport master (
        output sample_data,
        output sample_channel,
        output sample_uni,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_channel,
        input  sample_uni,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/ltc2308_serial_ctrl.sv
// LTC2308 serial controller: round-robin conversions over a channel mask, 6-bit config out on SDI,
// 12-bit result in from SDO, one-frame-delayed tagging, single-entry holding register with overrun.
module ltc2308_serial_ctrl #(
    parameter int unsigned CONVST_CYCLES = 2,
    parameter int unsigned CONV_CYCLES   = 64,
    parameter int unsigned SCK_HALF      = 1,
    parameter int unsigned GAP_CYCLES    = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic [7:0]                   channel_mask_i,
    input  logic                         uni_i,
    output logic                         adc_convst_o,
    output logic                         adc_sck_o,
    output logic                         adc_sdi_o,
    input  logic                         adc_sdo_i,
    ltc2308_serial_ctrl_if.master        sample_if,
    output logic                         overrun_o,
    input  logic                         overrun_clr_i,
    output logic                         busy_o
);

    localparam int unsigned    CW          = 16;
    localparam logic [CW-1:0]  CONVST_LAST = CW'(CONVST_CYCLES - 1);
    localparam logic [CW-1:0]  CONV_LAST   = CW'(CONV_CYCLES - 1);
    localparam logic [CW-1:0]  SCK_HI      = CW'(SCK_HALF);
    localparam logic [CW-1:0]  SCK_LAST    = CW'(2 * SCK_HALF - 1);
    localparam logic [CW-1:0]  GAP_LAST    = CW'(GAP_CYCLES - 1);
    localparam logic [3:0]     BIT_LAST    = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CONVST_HI = 3'd1,
        ST_CONV_WAIT = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_GAP       = 3'd4
    } state_e;

    // Lowest set mask bit strictly above cur, otherwise the lowest set bit overall.
    function automatic logic [2:0] next_channel(input logic [7:0] mask, input logic [2:0] cur);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                r = 3'(i);
            end else begin
                r = r;
            end
        end
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                r = 3'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Config word bit for SCK period idx (0-based): {S/D=1, O/S, S1, S0, UNI, SLP=0}.
    function automatic logic cfg_bit(input logic [2:0] ch, input logic uni, input logic [3:0] idx);
        logic b;
        case (idx)
            4'd0:    b = 1'b1;
            4'd1:    b = ch[0];
            4'd2:    b = ch[2];
            4'd3:    b = ch[1];
            4'd4:    b = uni;
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic          start_s;
    logic          run_s;

    logic          convst_q, convst_d;
    logic          sck_q, sck_d;
    logic          sdi_q, sdi_d;
    logic          busy_q, busy_d;

    logic [2:0]    cfg_ch_q, cfg_ch_d;
    logic          cfg_uni_q, cfg_uni_d;
    logic [2:0]    prev_ch_q, prev_ch_d;
    logic          prev_uni_q, prev_uni_d;
    logic          first_q, first_d;
    logic [10:0]   shift_q, shift_d;
    logic [11:0]   data_q, data_d;
    logic [2:0]    tag_ch_q, tag_ch_d;
    logic          tag_uni_q, tag_uni_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;

    logic          capture_s;
    logic          last_s;
    logic          deliver_s;
    logic          accept_s;
    logic          load_s;
    logic          drop_s;

    assign run_s     = enable_i && (channel_mask_i != 8'h00);
    assign capture_s = (state_q == ST_SHIFT) && (cnt_q == SCK_HI);
    assign last_s    = capture_s && (bit_q == BIT_LAST);
    assign deliver_s = last_s && !first_q;
    assign accept_s  = valid_q && sample_if.sample_ready;
    assign load_s    = deliver_s && (!valid_q || accept_s);
    assign drop_s    = deliver_s && !load_s;

    // FSM state and in-state timing counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    // FSM next state, counters and frame-start strobe
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = 4'd0;
                if (run_s) begin
                    state_d = ST_CONVST_HI;
                    start_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONVST_HI: begin
                if (cnt_q == CONVST_LAST) begin
                    state_d = ST_CONV_WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_CONVST_HI;
                end
            end
            ST_CONV_WAIT: begin
                if (cnt_q == CONV_LAST) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                end else begin
                    state_d = ST_CONV_WAIT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == SCK_LAST) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_GAP;
                        bit_d   = 4'd0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (run_s) begin
                        state_d = ST_CONVST_HI;
                        start_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                bit_d   = 4'd0;
            end
        endcase
    end

    // Pin values decoded from the next state so the registered pins line up with state_q
    always_comb begin
        convst_d = 1'b0;
        sck_d    = 1'b0;
        sdi_d    = 1'b0;
        case (state_d)
            ST_CONVST_HI: begin
                convst_d = 1'b1;
            end
            ST_SHIFT: begin
                sck_d = (cnt_d >= SCK_HI);
                sdi_d = cfg_bit(cfg_ch_q, cfg_uni_q, bit_d);
            end
            default: begin
                convst_d = 1'b0;
                sck_d    = 1'b0;
                sdi_d    = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Registered ADC pins and busy flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            convst_q <= 1'b0;
            sck_q    <= 1'b0;
            sdi_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            convst_q <= convst_d;
            sck_q    <= sck_d;
            sdi_q    <= sdi_d;
            busy_q   <= busy_d;
        end
    end

    // Channel selection, result shifting, holding register and overrun next-state
    always_comb begin
        if (start_s) begin
            prev_ch_d  = cfg_ch_q;
            prev_uni_d = cfg_uni_q;
            cfg_ch_d   = next_channel(channel_mask_i, cfg_ch_q);
            cfg_uni_d  = uni_i;
        end else begin
            prev_ch_d  = prev_ch_q;
            prev_uni_d = prev_uni_q;
            cfg_ch_d   = cfg_ch_q;
            cfg_uni_d  = cfg_uni_q;
        end

        // Returning to IDLE re-arms the discard of the first (stale-config) result
        if ((state_q != ST_IDLE) && (state_d == ST_IDLE)) begin
            first_d = 1'b1;
        end else if (last_s) begin
            first_d = 1'b0;
        end else begin
            first_d = first_q;
        end

        shift_d = capture_s ? {shift_q[9:0], adc_sdo_i} : shift_q;

        if (load_s) begin
            data_d    = {shift_q, adc_sdo_i};
            tag_ch_d  = prev_ch_q;
            tag_uni_d = prev_uni_q;
            valid_d   = 1'b1;
        end else if (accept_s) begin
            data_d    = data_q;
            tag_ch_d  = tag_ch_q;
            tag_uni_d = tag_uni_q;
            valid_d   = 1'b0;
        end else begin
            data_d    = data_q;
            tag_ch_d  = tag_ch_q;
            tag_uni_d = tag_uni_q;
            valid_d   = valid_q;
        end

        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (overrun_clr_i) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Config, shift and sample holding registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_ch_q   <= 3'd7;
            cfg_uni_q  <= 1'b0;
            prev_ch_q  <= 3'd0;
            prev_uni_q <= 1'b0;
            first_q    <= 1'b1;
            shift_q    <= 11'd0;
            data_q     <= 12'd0;
            tag_ch_q   <= 3'd0;
            tag_uni_q  <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            cfg_ch_q   <= cfg_ch_d;
            cfg_uni_q  <= cfg_uni_d;
            prev_ch_q  <= prev_ch_d;
            prev_uni_q <= prev_uni_d;
            first_q    <= first_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            tag_ch_q   <= tag_ch_d;
            tag_uni_q  <= tag_uni_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign adc_convst_o             = convst_q;
    assign adc_sck_o                = sck_q;
    assign adc_sdi_o                = sdi_q;
    assign busy_o                   = busy_q;
    assign overrun_o                = overrun_q;
    assign sample_if.sample_data    = data_q;
    assign sample_if.sample_channel = tag_ch_q;
    assign sample_if.sample_uni     = tag_uni_q;
    assign sample_if.sample_valid   = valid_q;

endmodule

// File: tb/tb_ltc2308_serial_ctrl.sv
// Directed bench for ltc2308_serial_ctrl: per-frame vector table plus hand sequences for
// overrun, coincident events, enable drop mid-shift and reset mid-conversion.
module tb_ltc2308_serial_ctrl;

    localparam int LAT   = 2 + 64 + 24;  // frame start to sample_valid visible
    localparam int FRAME = 2 + 64 + 24 + 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] channel_mask;
    logic       uni;
    logic       adc_convst, adc_sck, adc_sdi, adc_sdo;
    logic       overrun, overrun_clr, busy;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    ltc2308_serial_ctrl_if sif();

    ltc2308_serial_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .channel_mask_i (channel_mask),
        .uni_i          (uni),
        .adc_convst_o   (adc_convst),
        .adc_sck_o      (adc_sck),
        .adc_sdi_o      (adc_sdi),
        .adc_sdo_i      (adc_sdo),
        .sample_if      (sif),
        .overrun_o      (overrun),
        .overrun_clr_i  (overrun_clr),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  mask;
        logic        uni;
        logic [11:0] sdo;
        logic [5:0]  exp_sdi;
        logic        exp_sample;
        logic [2:0]  exp_ch;
        logic        exp_uni;
        logic [11:0] exp_data;
    } vec_t;

    vec_t vec [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Wait for CONVST, play the ADC side of one frame, return at the negedge after the 12th SCK rise.
    task automatic run_frame(input logic [11:0] word, input bit drop_en, input bit ready_last,
                             input bit clr_last, output logic [5:0] sdi_w, output int t0,
                             output bit ok);
        int   n;
        int   k;
        logic ps;
        ok    = 1'b1;
        sdi_w = 6'd0;
        t0    = 0;
        n     = 0;
        while (adc_convst !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            ok = 1'b0;
        end else begin
            t0 = cyc;
            k  = 0;
            n  = 0;
            ps = 1'b0;
            while (k < 12 && n < 400) begin
                @(negedge clk);
                n++;
                if (adc_sck === 1'b1 && ps === 1'b0) begin
                    if (k < 6) sdi_w[5-k] = adc_sdi;
                    adc_sdo = word[11-k];
                    if (drop_en && k == 0) enable = 1'b0;
                    if (k == 11 && ready_last) sif.sample_ready = 1'b1;
                    if (k == 11 && clr_last) overrun_clr = 1'b1;
                    k++;
                end
                ps = adc_sck;
            end
            if (k < 12) ok = 1'b0;
            @(negedge clk);
            adc_sdo = 1'b0;
        end
    endtask

    initial begin
        logic [5:0] sdi_w;
        int         t0;
        int         prev_t0;
        int         n;
        bit         ok;

        vec[0] = '{8'h01, 1'b1, 12'hA5C, 6'b100010, 1'b0, 3'd0, 1'b0, 12'h000};
        vec[1] = '{8'h01, 1'b1, 12'hA5C, 6'b100010, 1'b1, 3'd0, 1'b1, 12'hA5C};
        vec[2] = '{8'h94, 1'b1, 12'h123, 6'b100110, 1'b1, 3'd0, 1'b1, 12'h123};
        vec[3] = '{8'h94, 1'b1, 12'h456, 6'b101010, 1'b1, 3'd2, 1'b1, 12'h456};
        vec[4] = '{8'h94, 1'b1, 12'h789, 6'b111110, 1'b1, 3'd4, 1'b1, 12'h789};
        vec[5] = '{8'h94, 1'b1, 12'hFFF, 6'b100110, 1'b1, 3'd7, 1'b1, 12'hFFF};
        vec[6] = '{8'h94, 1'b0, 12'h000, 6'b101000, 1'b1, 3'd2, 1'b1, 12'h000};
        vec[7] = '{8'h81, 1'b0, 12'h800, 6'b111100, 1'b1, 3'd4, 1'b0, 12'h800};
        vec[8] = '{8'h81, 1'b1, 12'h001, 6'b100010, 1'b1, 3'd7, 1'b0, 12'h001};

        rst = 1'b1; enable = 1'b0; channel_mask = 8'h00; uni = 1'b0;
        adc_sdo = 1'b0; overrun_clr = 1'b0; sif.sample_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_convst", {31'd0, adc_convst}, 32'd0);
        check("rst_valid", {31'd0, sif.sample_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        enable = 1'b1;

        prev_t0 = 0;
        for (int i = 0; i < 9; i++) begin
            channel_mask = vec[i].mask;
            uni = vec[i].uni;
            run_frame(vec[i].sdo, 1'b0, 1'b0, 1'b0, sdi_w, t0, ok);
            check("frame_done", {31'd0, ok}, 32'd1);
            check("sdi_word", {26'd0, sdi_w}, {26'd0, vec[i].exp_sdi});
            check("valid", {31'd0, sif.sample_valid}, {31'd0, vec[i].exp_sample});
            if (vec[i].exp_sample) begin
                check("data", {20'd0, sif.sample_data}, {20'd0, vec[i].exp_data});
                check("chan", {29'd0, sif.sample_channel}, {29'd0, vec[i].exp_ch});
                check("uni", {31'd0, sif.sample_uni}, {31'd0, vec[i].exp_uni});
                check("latency", cyc - t0, LAT);
            end
            if (i > 0) check("frame_period", t0 - prev_t0, FRAME);
            prev_t0 = t0;
        end

        // Consumer stalls: row-8 sample held, later ones dropped
        sif.sample_ready = 1'b0;
        check("ovr_before", {31'd0, overrun}, 32'd0);
        run_frame(12'h111, 1'b0, 1'b0, 1'b0, sdi_w, t0, ok);
        check("f9_done", {31'd0, ok}, 32'd1);
        check("f9_overrun", {31'd0, overrun}, 32'd1);
        check("f9_hold", {20'd0, sif.sample_data}, 32'h001);
        run_frame(12'h222, 1'b0, 1'b0, 1'b0, sdi_w, t0, ok);
        check("f10_hold", {20'd0, sif.sample_data}, 32'h001);
        check("f10_chan", {29'd0, sif.sample_channel}, 32'd7);
        check("f10_valid", {31'd0, sif.sample_valid}, 32'd1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        @(negedge clk);
        check("ovr_clr", {31'd0, overrun}, 32'd0);

        // Accept coinciding with delivery: replace, no overrun
        run_frame(12'h3C3, 1'b0, 1'b1, 1'b0, sdi_w, t0, ok);
        sif.sample_ready = 1'b0;
        check("coinc_valid", {31'd0, sif.sample_valid}, 32'd1);
        check("coinc_data", {20'd0, sif.sample_data}, 32'h3C3);
        check("coinc_chan", {29'd0, sif.sample_channel}, 32'd0);
        check("coinc_ovr", {31'd0, overrun}, 32'd0);

        // Clear coinciding with a new overrun: set wins
        run_frame(12'h444, 1'b0, 1'b0, 1'b1, sdi_w, t0, ok);
        overrun_clr = 1'b0;
        check("setwins_ovr", {31'd0, overrun}, 32'd1);
        check("setwins_hold", {20'd0, sif.sample_data}, 32'h3C3);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        sif.sample_ready = 1'b1;
        @(negedge clk);
        check("ovr_clr2", {31'd0, overrun}, 32'd0);
        check("drained", {31'd0, sif.sample_valid}, 32'd0);
        sif.sample_ready = 1'b0;

        // Enable dropped during SHIFT: frame completes and delivers, then IDLE
        run_frame(12'h5A6, 1'b1, 1'b0, 1'b0, sdi_w, t0, ok);
        check("drop_done", {31'd0, ok}, 32'd1);
        check("drop_sdi", {26'd0, sdi_w}, 32'b111110);
        check("drop_valid", {31'd0, sif.sample_valid}, 32'd1);
        check("drop_data", {20'd0, sif.sample_data}, 32'h5A6);
        check("drop_chan", {29'd0, sif.sample_channel}, 32'd0);
        repeat (3) @(negedge clk);
        check("busy_gap", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("busy_idle", {31'd0, busy}, 32'd0);
        n = 0;
        repeat (150) begin
            @(negedge clk);
            if (adc_convst === 1'b1) n++;
        end
        check("no_convst", n, 0);

        // Re-enable: first frame discarded (holding full, so a wrong delivery would overrun)
        channel_mask = 8'h10; uni = 1'b0; enable = 1'b1;
        run_frame(12'hFFF, 1'b0, 1'b0, 1'b0, sdi_w, t0, ok);
        check("reen_sdi", {26'd0, sdi_w}, 32'b101000);
        check("reen_ovr", {31'd0, overrun}, 32'd0);
        check("reen_hold", {20'd0, sif.sample_data}, 32'h5A6);

        // Reset in CONV_WAIT
        n = 0;
        while (adc_convst !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("convst_seen", {31'd0, adc_convst}, 32'd1);
        repeat (10) @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, sif.sample_valid}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_data", {20'd0, sif.sample_data}, 32'd0);
        check("arst_pins", {29'd0, adc_convst, adc_sck, adc_sdi}, 32'd0);
        @(negedge clk);
        channel_mask = 8'h81; uni = 1'b1; sif.sample_ready = 1'b1;
        rst = 1'b0;
        run_frame(12'hABC, 1'b0, 1'b0, 1'b0, sdi_w, t0, ok);
        check("post_sdi1", {26'd0, sdi_w}, 32'b100010);
        check("post_valid1", {31'd0, sif.sample_valid}, 32'd0);
        run_frame(12'h0F0, 1'b0, 1'b0, 1'b0, sdi_w, t0, ok);
        check("post_sdi2", {26'd0, sdi_w}, 32'b111110);
        check("post_valid2", {31'd0, sif.sample_valid}, 32'd1);
        check("post_data2", {20'd0, sif.sample_data}, 32'h0F0);
        check("post_chan2", {29'd0, sif.sample_channel}, 32'd0);
        check("post_uni2", {31'd0, sif.sample_uni}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ltc2308_serial_ctrl.md
Name: ltc2308_serial_ctrl

Overview:
Drives the LTC2308 8-channel 12-bit ADC serial pins (CONVST, SCK, SDI, SDO) on the DE1-SoC ADC conduit. It sequences conversions round-robin over a channel mask, shifts out the 6-bit config word, and shifts in the 12-bit result. Completed samples are presented to the downstream consumer (sample buffer or Avalon register slave) on a valid/ready interface, tagged with channel and mode.

Parameters:
CONVST_CYCLES, 2, clk cycles adc_convst is held high per frame (>=20 ns at 40 MHz)
CONV_CYCLES, 64, clk cycles waited after CONVST falls before shifting (>=1.6 us at 40 MHz)
SCK_HALF, 1, clk cycles per SCK half-period (SCK = clk/(2*SCK_HALF)); must be >=1
GAP_CYCLES, 4, idle clk cycles after the last SCK before the next frame

Ports:
clk  in  1  system clock (40 MHz PLL output)
reset  in  1  asynchronous, active-high reset
enable  in  1  level; 1 = run continuous frames
channel_mask  in  8  bit n = include channel n in the sequence
uni  in  1  1 = unipolar, 0 = bipolar; sampled at frame start
adc_convst  out  1  LTC2308 CONVST
adc_sck  out  1  LTC2308 SCK
adc_sdi  out  1  LTC2308 SDI (config word)
adc_sdo  in  1  LTC2308 SDO
sample_data  out  12  raw conversion result, MSB first from SDO
sample_channel  out  3  channel of sample_data
sample_uni  out  1  mode of sample_data
sample_valid  out  1  sample holding register full
sample_ready  in  1  consumer accepts when valid & ready
overrun  out  1  sticky; sample lost because holding register was full
overrun_clr  in  1  synchronous clear of overrun
busy  out  1  1 when FSM is not IDLE

Behaviour:
- Reset (async) sets all outputs to 0, FSM to IDLE, holding register empty, the first-frame flag to set, and the current channel to 7. Reset mid-frame aborts the frame immediately.
- FSM states: IDLE -> CONVST_HI -> CONV_WAIT -> SHIFT -> GAP -> (CONVST_HI | IDLE).
- IDLE: when enable=1 and channel_mask!=0, go to CONVST_HI.
  - Channel select at that transition: the next channel is the lowest set mask bit strictly above the current channel. If there is none, wrap to the lowest set mask bit.
  - Latch the selected channel and uni into cfg_ch/cfg_uni.
- CONVST_HI: adc_convst=1 for CONVST_CYCLES cycles, then 0.
- CONV_WAIT: CONV_CYCLES cycles with adc_convst=0 and adc_sck=0.
- SHIFT: 12 SCK periods. Each period is SCK_HALF cycles low, then SCK_HALF cycles high. adc_sck idles low.
  - adc_sdi presents config bits in SCK periods 1-6, MSB first, stable for the whole period: {1, cfg_ch[0], cfg_ch[2], cfg_ch[1], cfg_uni, 0} (single-ended, SLP=0).
  - adc_sdi=0 in periods 7-12.
  - adc_sdo is captured in the clk cycle in which adc_sck rises. The 1st capture is bit 11, the 12th is bit 0.
- GAP: GAP_CYCLES cycles, all pins low.
  - On GAP exit: if enable=1 and mask!=0, go to CONVST_HI with the next-channel selection above; otherwise go to IDLE.
- Pipeline: LTC2308 applies a config word to the following conversion. The result shifted in a frame therefore belongs to the config of the previous frame; the block keeps prev_ch/prev_uni for tagging.
  - The first frame after IDLE or reset produces no sample (first-frame flag); the flag clears after that frame.
  - Frame length with defaults = 2+64+24+4 = 94 clk.
- Sample delivery happens in the cycle after the 12th capture.
  - Holding register empty, or valid&ready in the same cycle: load {data, prev_ch, prev_uni} and set sample_valid=1.
  - Otherwise: drop the new sample, keep the held one, and set overrun=1.
- sample_valid clears on valid&ready when no new load occurs in that cycle.
- overrun_clr clears overrun. If overrun_clr and a new overrun occur in the same cycle, the set wins.
- enable deasserted mid-frame: the frame completes, its sample is delivered, then the FSM goes to IDLE. Re-enabling sets the first-frame flag again.
- Changes to channel_mask or uni take effect at the next frame-start selection only. A mask going to 0 mid-frame causes GAP -> IDLE.

Test Plan:
- Reset, enable=1, mask=0x01, uni=1, SDO model returns 0xA5C:
  - Frame 1 produces no sample.
  - Frame 2 gives sample_valid=1 at cycle 188±1 with data=0xA5C, channel=0, uni=1.
  - SDI word per frame = 100010.
- mask=0x94 (channels 2,4,7), ready=1:
  - SDI channel order is 2,4,7,2,...
  - Output channel tags lag by one frame: 2,4,7,2.
  - SDI words are 100110, 101010, 111110.
- ready=0 for 3 frames after the first valid: the first sample is held unchanged and overrun=1 after the second delivery. overrun_clr pulse -> overrun=0.
- Simultaneous events:
  - valid&ready in the exact delivery cycle: new sample loaded, valid stays 1, overrun stays 0.
  - overrun_clr coinciding with an overrun: overrun stays 1.
- Deassert enable during SHIFT of frame 5: frame 5 completes, its sample is delivered, busy falls at GAP end, and no CONVST follows.
- Assert reset mid-CONV_WAIT: all outputs are 0 immediately. On re-enable, the first frame is discarded and the next sample carries the channel of the first post-reset config.
